// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction sequencer.
// Credit is held in rupees; every amount handled is a multiple of 5.
package vend_pkg;

    localparam int CREDIT_W    = 6;
    localparam int COIN5_VAL   = 5;
    localparam int COIN10_VAL  = 10;
    localparam int DEF_PRICE_0 = 5;
    localparam int DEF_PRICE_1 = 10;
    localparam int DEF_PRICE_2 = 15;
    localparam int DEF_PRICE_3 = 20;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_COLLECT  = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_t;

    // Both coin pulses in the same cycle are worth 15.
    function automatic logic [CREDIT_W-1:0] coin_value(input logic c5, input logic c10);
        logic [CREDIT_W-1:0] v5;
        logic [CREDIT_W-1:0] v10;
        v5  = c5  ? CREDIT_W'(COIN5_VAL)  : {CREDIT_W{1'b0}};
        v10 = c10 ? CREDIT_W'(COIN10_VAL) : {CREDIT_W{1'b0}};
        return v5 + v10;
    endfunction

endpackage

// File: rtl/vend_timeout.sv
// Inactivity counter: clears on request, counts while enabled and
// saturates at TIMEOUT-1, where expire is flagged.
module vend_timeout #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] r_cnt;

    // Idle-cycle counter with clear priority over count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (i_en && (r_cnt != LAST)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_expire = (r_cnt == LAST);

endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: selection, coin collection, dispense
// strobe and 5-rupee change train, with cancel/timeout refund.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int PRICE_0 = DEF_PRICE_0,
    parameter int PRICE_1 = DEF_PRICE_1,
    parameter int PRICE_2 = DEF_PRICE_2,
    parameter int PRICE_3 = DEF_PRICE_3,
    parameter int TIMEOUT = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          product,
    input  logic                sel_valid,
    input  logic                coin5,
    input  logic                coin10,
    input  logic                cancel,
    output logic                dispense,
    output logic [1:0]          dispense_id,
    output logic                ret5,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy
);

    state_t              r_state;
    logic [CREDIT_W-1:0] r_credit;
    logic [CREDIT_W-1:0] r_price;
    logic [1:0]          r_product;
    logic                r_dispense;
    logic [1:0]          r_dispense_id;
    logic                r_ret5;
    logic                r_coin_reject;
    logic                r_busy;

    logic                w_any_coin;
    logic [CREDIT_W-1:0] w_coin_val;
    logic [CREDIT_W-1:0] w_collect_credit;
    logic [CREDIT_W-1:0] w_remainder;
    logic [CREDIT_W-1:0] w_change_next;
    logic [CREDIT_W-1:0] w_sel_price;
    logic                w_tmo_clr;
    logic                w_tmo_en;
    logic                w_expire;

    // Credit arithmetic and price lookup feeding the state machine.
    always_comb begin
        w_any_coin       = coin5 | coin10;
        w_coin_val       = coin_value(coin5, coin10);
        w_collect_credit = r_credit + w_coin_val;
        w_remainder      = r_credit - r_price;
        if (r_credit != {CREDIT_W{1'b0}}) begin
            w_change_next = r_credit - CREDIT_W'(COIN5_VAL);
        end else begin
            w_change_next = {CREDIT_W{1'b0}};
        end
        case (product)
            2'b00:   w_sel_price = CREDIT_W'(PRICE_0);
            2'b01:   w_sel_price = CREDIT_W'(PRICE_1);
            2'b10:   w_sel_price = CREDIT_W'(PRICE_2);
            2'b11:   w_sel_price = CREDIT_W'(PRICE_3);
            default: w_sel_price = CREDIT_W'(PRICE_0);
        endcase
    end

    // The counter is held at zero outside COLLECT, so entry always starts fresh.
    assign w_tmo_clr = (r_state != ST_COLLECT) | w_any_coin;
    assign w_tmo_en  = (r_state == ST_COLLECT);

    vend_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_clr    (w_tmo_clr),
        .i_en     (w_tmo_en),
        .o_expire (w_expire)
    );

    // Transaction FSM; outputs are registered alongside the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_credit      <= {CREDIT_W{1'b0}};
            r_price       <= {CREDIT_W{1'b0}};
            r_product     <= 2'b00;
            r_dispense    <= 1'b0;
            r_dispense_id <= 2'b00;
            r_ret5        <= 1'b0;
            r_coin_reject <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_dispense    <= 1'b0;
            r_dispense_id <= 2'b00;
            r_ret5        <= 1'b0;
            r_coin_reject <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_credit      <= {CREDIT_W{1'b0}};
                    r_coin_reject <= w_any_coin;
                    if (sel_valid) begin
                        r_product <= product;
                        r_price   <= w_sel_price;
                        r_state   <= ST_COLLECT;
                        r_busy    <= 1'b1;
                    end else begin
                        r_busy    <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    r_credit <= w_collect_credit;
                    // Cancel wins over a payment completing in the same cycle.
                    if (cancel) begin
                        r_state <= ST_CHANGE;
                        r_ret5  <= (w_collect_credit != {CREDIT_W{1'b0}});
                    end else if (w_collect_credit >= r_price) begin
                        r_state       <= ST_DISPENSE;
                        r_dispense    <= 1'b1;
                        r_dispense_id <= r_product;
                    end else if (w_expire && !w_any_coin) begin
                        r_state <= ST_CHANGE;
                        r_ret5  <= (w_collect_credit != {CREDIT_W{1'b0}});
                    end else begin
                        r_state <= ST_COLLECT;
                    end
                end
                ST_DISPENSE: begin
                    r_coin_reject <= w_any_coin;
                    r_credit      <= w_remainder;
                    if (w_remainder != {CREDIT_W{1'b0}}) begin
                        r_state <= ST_CHANGE;
                        r_ret5  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_CHANGE: begin
                    r_coin_reject <= w_any_coin;
                    r_credit      <= w_change_next;
                    if (w_change_next != {CREDIT_W{1'b0}}) begin
                        r_ret5  <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_credit <= {CREDIT_W{1'b0}};
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign dispense    = r_dispense;
    assign dispense_id = r_dispense_id;
    assign ret5        = r_ret5;
    assign coin_reject = r_coin_reject;
    assign credit      = r_credit;
    assign busy        = r_busy;

endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Randomised bench for vend_txn_ctrl with a transaction-level reference
// model (output schedules built per transaction) plus directed scenarios.
module tb_vend_txn_ctrl;

    localparam int TMO = 8;

    typedef struct packed {
        logic       disp;
        logic [1:0] id;
        logic       ret5;
        logic [5:0] cred;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] product = 2'b00;
    logic       sel_valid = 1'b0;
    logic       coin5 = 1'b0;
    logic       coin10 = 1'b0;
    logic       cancel = 1'b0;
    logic       dispense;
    logic [1:0] dispense_id;
    logic       ret5;
    logic       coin_reject;
    logic [5:0] credit;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;

    vend_txn_ctrl #(
        .PRICE_0 (5),
        .PRICE_1 (10),
        .PRICE_2 (15),
        .PRICE_3 (20),
        .TIMEOUT (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .product     (product),
        .sel_valid   (sel_valid),
        .coin5       (coin5),
        .coin10      (coin10),
        .cancel      (cancel),
        .dispense    (dispense),
        .dispense_id (dispense_id),
        .ret5        (ret5),
        .coin_reject (coin_reject),
        .credit      (credit),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int   price_tab [4] = '{5, 10, 15, 20};
    int   m_credit, m_price, m_idle, nc, coins;
    logic [1:0] m_prod;
    bit   m_coll, m_seq, anyc;
    rec_t sched [$];
    rec_t r;
    logic       e_disp, e_ret5, e_rej, e_busy;
    logic [1:0] e_id;
    logic [5:0] e_cred;

    task automatic push_change(input int amount);
        rec_t c;
        if (amount == 0) begin
            c = '{disp: 1'b0, id: 2'b00, ret5: 1'b0, cred: 6'd0};
            sched.push_back(c);
        end else begin
            for (int i = 0; i < amount / 5; i++) begin
                c = '{disp: 1'b0, id: 2'b00, ret5: 1'b1, cred: 6'(amount - 5 * i)};
                sched.push_back(c);
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_credit = 0; m_price = 0; m_idle = 0; m_prod = 2'b00;
            m_coll = 1'b0; m_seq = 1'b0; sched.delete();
            e_disp = 1'b0; e_id = 2'b00; e_ret5 = 1'b0; e_rej = 1'b0;
            e_cred = 6'd0; e_busy = 1'b0;
        end else begin
            coins = (coin5 ? 5 : 0) + (coin10 ? 10 : 0);
            anyc  = coin5 | coin10;
            e_disp = 1'b0; e_id = 2'b00; e_ret5 = 1'b0; e_rej = 1'b0;
            if (!m_seq && m_coll) begin
                nc = m_credit + coins;
                if (cancel || (nc < m_price && !anyc && m_idle == TMO - 1)) begin
                    m_coll = 1'b0;
                    push_change(nc);
                    m_seq = 1'b1;
                end else if (nc >= m_price) begin
                    m_coll = 1'b0;
                    r = '{disp: 1'b1, id: m_prod, ret5: 1'b0, cred: 6'(nc)};
                    sched.push_back(r);
                    if (nc - m_price > 0) push_change(nc - m_price);
                    m_seq = 1'b1;
                end else begin
                    m_credit = nc;
                    m_idle   = anyc ? 0 : m_idle + 1;
                    e_cred   = 6'(nc);
                    e_busy   = 1'b1;
                end
                if (m_seq) begin
                    r = sched.pop_front();
                    e_disp = r.disp; e_id = r.id; e_ret5 = r.ret5; e_cred = r.cred;
                    e_busy = 1'b1;
                end
            end else if (m_seq) begin
                e_rej = anyc;
                if (sched.size() > 0) begin
                    r = sched.pop_front();
                    e_disp = r.disp; e_id = r.id; e_ret5 = r.ret5; e_cred = r.cred;
                    e_busy = 1'b1;
                end else begin
                    m_seq = 1'b0; e_cred = 6'd0; e_busy = 1'b0;
                end
            end else begin
                e_rej  = anyc;
                e_cred = 6'd0;
                if (sel_valid) begin
                    m_coll = 1'b1; m_prod = product; m_price = price_tab[product];
                    m_credit = 0; m_idle = 0; e_busy = 1'b1;
                end else begin
                    e_busy = 1'b0;
                end
            end
        end
    end

    // ---------------- compare + event counters ----------------
    int n_disp, n_ret5, n_rej, max_cred;
    logic [1:0] last_id;

    always @(negedge clk) begin
        if (rst_n) begin
            n_cmp++;
            if ({dispense, dispense_id, ret5, coin_reject, credit, busy} !==
                {e_disp, e_id, e_ret5, e_rej, e_cred, e_busy}) begin
                n_err++;
                $display("FAIL model t=%0t got disp=%b id=%b ret5=%b rej=%b cred=%0d busy=%b want disp=%b id=%b ret5=%b rej=%b cred=%0d busy=%b",
                         $time, dispense, dispense_id, ret5, coin_reject, credit, busy,
                         e_disp, e_id, e_ret5, e_rej, e_cred, e_busy);
            end
            if (dispense) begin n_disp++; last_id = dispense_id; end
            if (ret5) n_ret5++;
            if (coin_reject) n_rej++;
            if (int'(credit) > max_cred) max_cred = int'(credit);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic clr_cnt();
        n_disp = 0; n_ret5 = 0; n_rej = 0; max_cred = 0; last_id = 2'b00;
    endtask

    task automatic step(input logic s, input logic [1:0] p, input logic c5,
                        input logic c10, input logic cn);
        sel_valid = s; product = p; coin5 = c5; coin10 = c10; cancel = cn;
        @(posedge clk);
        #2;
        sel_valid = 1'b0; coin5 = 1'b0; coin10 = 1'b0; cancel = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;
        bit quiet;
        int len;
        repeat (2) @(posedge clk);
        #2;
        chk("reset_outputs", int'({dispense, dispense_id, ret5, coin_reject, credit, busy}), 0);
        rst_n = 1'b1;
        idle(2);

        // product 0, exact payment
        clr_cnt();
        step(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        idle(4);
        chk("p0_dispense", n_disp, 1);
        chk("p0_id", int'(last_id), 0);
        chk("p0_ret5", n_ret5, 0);
        chk("p0_credit_end", int'(credit), 0);

        // product 2, 20 paid, one coin back
        clr_cnt();
        step(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        idle(5);
        chk("p2_dispense", n_disp, 1);
        chk("p2_id", int'(last_id), 2);
        chk("p2_ret5", n_ret5, 1);
        chk("p2_max_credit", max_cred, 20);

        // product 3, double coin then 10
        clr_cnt();
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b1, 1'b0);
        chk("p3_credit15", int'(credit), 15);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        idle(5);
        chk("p3_max_credit", max_cred, 25);
        chk("p3_dispense", n_disp, 1);
        chk("p3_ret5", n_ret5, 1);

        // cancel refund, then coin in idle
        clr_cnt();
        step(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        idle(4);
        chk("cancel_ret5", n_ret5, 1);
        chk("cancel_dispense", n_disp, 0);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("idle_reject", int'(coin_reject), 1);
        chk("idle_credit", int'(credit), 0);
        idle(2);
        chk("idle_reject_count", n_rej, 1);

        // timeout refund of 10
        clr_cnt();
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        idle(TMO + 6);
        chk("timeout_ret5", n_ret5, 2);
        chk("timeout_dispense", n_disp, 0);
        chk("timeout_busy", int'(busy), 0);

        // reset in the middle of a 15-rupee refund
        step(1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'b00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 2'b00, 1'b1, 1'b0, 1'b0);
        seen = 1'b0;
        for (int i = 0; i < 4 * TMO && !seen; i++) begin
            if (ret5) seen = 1'b1;
            else idle(1);
        end
        chk("refund_started", int'(seen), 1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", int'({dispense, dispense_id, ret5, coin_reject, credit, busy}), 0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle(2);

        // randomised traffic
        for (int b = 0; b < 300; b++) begin
            quiet = ($urandom_range(0, 3) == 0);
            len   = $urandom_range(1, 15);
            for (int j = 0; j < len; j++) begin
                if (quiet) begin
                    idle(1);
                end else begin
                    step($urandom_range(0, 99) < 15, 2'($urandom_range(0, 3)),
                         $urandom_range(0, 99) < 25, $urandom_range(0, 99) < 20,
                         $urandom_range(0, 99) < 4);
                end
            end
        end
        idle(TMO + 10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/vend_txn_ctrl.md
# vend_txn_ctrl

Transaction sequencer for the coin-operated vending machine. Accepts a product selection, accumulates 5- and 10-rupee coin pulses into a credit register, fires a one-cycle dispense strobe when credit covers the price, then returns change as a train of 5-rupee coin-return pulses. Sits between the coin acceptor / keypad front end and the dispense and change-hopper actuators. Handles cancel and inactivity timeout by refunding all credit.

## Interface
Parameters:
- PRICE_0, 5, price in rupees of product 2'b00
- PRICE_1, 10, price of product 2'b01
- PRICE_2, 15, price of product 2'b10
- PRICE_3, 20, price of product 2'b11
- TIMEOUT, 1000, idle cycles in COLLECT before automatic refund (≥2)

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- product  in  2  product code, sampled when sel_valid=1
- sel_valid  in  1  one-cycle selection strobe
- coin5  in  1  one-cycle pulse: 5-rupee coin inserted
- coin10  in  1  one-cycle pulse: 10-rupee coin inserted
- cancel  in  1  one-cycle pulse: abort and refund
- dispense  out  1  one-cycle strobe: release product
- dispense_id  out  2  product code, valid while dispense=1
- ret5  out  1  one-cycle pulse per 5-rupee coin returned
- coin_reject  out  1  one-cycle pulse: inserted coin(s) not accepted, routed to reject chute
- credit  out  6  current credit in rupees
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, COLLECT, DISPENSE, CHANGE.
- IDLE: credit=0. sel_valid → latch product and its price, go COLLECT. Coins in IDLE → coin_reject next cycle, credit unchanged. sel_valid and a coin in the same cycle: selection taken, coin rejected.
- COLLECT: credit += 5·coin5 + 10·coin10 (both in one cycle → +15). If new credit ≥ price → DISPENSE. sel_valid ignored (no reselect).
- cancel in COLLECT → CHANGE; any coin in the same cycle is added first and refunded. cancel beats price-reached in the same cycle.
- Timeout counter reloads to 0 on entry to COLLECT and on every accepted coin; reaching TIMEOUT−1 → CHANGE (refund). Zero credit on timeout/cancel → CHANGE exits to IDLE next cycle with no ret5.
- DISPENSE: one cycle; dispense=1, dispense_id=latched product; credit −= price. → CHANGE if remainder >0, else IDLE.
- CHANGE: each cycle ret5=1 and credit −= 5; when credit reaches 0 → IDLE (last ret5 coincides with transition).
- Coins in DISPENSE or CHANGE: rejected (coin_reject), credit unaffected. cancel in DISPENSE/CHANGE ignored.
- Arithmetic: all amounts multiples of 5; credit max 20+15−5=30 at ≤20 price, 6 bits sufficient; no overflow possible with parameters ≤40.

## Timing
- All outputs registered. Reset: state IDLE, credit 0, dispense 0, dispense_id 0, ret5 0, coin_reject 0, busy 0, timeout counter 0.
- Coin completing payment sampled at edge N → dispense high in cycle after edge N (1-cycle latency); first ret5 in following cycle.
- Change of C rupees → exactly C/5 consecutive ret5 cycles.
- coin_reject high exactly one cycle after the offending coin cycle.
- rst_n assertion mid-transaction clears everything immediately; credit is lost (no refund) — documented system behaviour.

## Structure
- Package vend_pkg: state enum, coin value constants (5, 10), default prices, credit width (6).
- Sub-module vend_timeout: counter with clear/enable inputs and expire output, parameterised by TIMEOUT.

## Test plan
- Select 2'b00, coin5 → dispense=1, dispense_id=00, no ret5, back to IDLE, credit 0.
- Select 2'b10, coin10 then coin10 → dispense id 10, then one ret5 pulse, credit 20→5→0.
- Select 2'b11, coin5 and coin10 same cycle, then coin10 → credit 15 then 25, dispense, one ret5.
- Select 2'b01, coin5, cancel → one ret5, no dispense; coin in IDLE → coin_reject, credit 0.
- Select 2'b11, coin10, wait TIMEOUT cycles → two ret5 pulses, IDLE; rst_n low during CHANGE → all outputs 0 asynchronously.
